// File: rtl/cplx_div_seq_pkg.sv
// Shared definitions for the complex-divide sequencer: FSM encoding,
// default widths, divider port widths and the rounding helper.
// Optional feature macro: CPLX_ROUND_EN (round-to-nearest quotients).
package cplx_div_pkg;

  localparam int W_DEF       = 8;
  localparam int FRAC_DEF    = 8;

  localparam int DIVIDEND_W  = 32;
  localparam int DIVISOR_W   = 16;
  localparam int QUOTIENT_W  = 32;

  // Cycles from the divider's run pulse to its stop cycle inclusive.
  localparam int DIV_LATENCY = 33;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CALC    = 3'd1;
  localparam state_t ST_RUN_RE  = 3'd2;
  localparam state_t ST_WAIT_RE = 3'd3;
  localparam state_t ST_CAP_RE  = 3'd4;
  localparam state_t ST_WAIT_IM = 3'd5;
  localparam state_t ST_CAP_IM  = 3'd6;
  localparam state_t ST_DONE    = 3'd7;

  // Moves a numerator half a divisor away from zero so that the divider's
  // truncation becomes round-to-nearest with ties away from zero.
  function automatic logic signed [DIVIDEND_W-1:0] round_bias(
    input logic signed [DIVIDEND_W-1:0] n,
    input logic        [DIVISOR_W-1:0]  d
  );
    logic signed [DIVIDEND_W-1:0] half;
    half = signed'({{(DIVIDEND_W-DIVISOR_W){1'b0}}, d >> 1});
    if (n > 0)      return n + half;
    else if (n < 0) return n - half;
    return n;
  endfunction

endpackage

// File: rtl/cplx_div_seq_if.sv
// Bundle of the operand, result and divider-side signals of cplx_div_seq.
// slave: the sequencer's view. master: the environment's view.
interface cplx_div_seq_if
  import cplx_div_pkg::*;
#(
  parameter int W = W_DEF
) ();

  // operand channel
  logic                         in_valid;
  logic                         in_ready;
  logic signed [W-1:0]          a_re;
  logic signed [W-1:0]          a_im;
  logic signed [W-1:0]          b_re;
  logic signed [W-1:0]          b_im;

  // result channel
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOTIENT_W-1:0] q_re;
  logic signed [QUOTIENT_W-1:0] q_im;
  logic                         dz;

  // shared sequential divider
  logic                         div_run;
  logic signed [DIVIDEND_W-1:0] div_dividend;
  logic        [DIVISOR_W-1:0]  div_divisor;
  logic                         div_busy;
  logic                         div_stop;
  logic signed [QUOTIENT_W-1:0] div_quotient;

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  div_busy, div_stop, div_quotient,
    output in_ready, out_valid, q_re, q_im, dz,
    output div_run, div_dividend, div_divisor
  );

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready,
    output div_busy, div_stop, div_quotient,
    input  in_ready, out_valid, q_re, q_im, dz,
    input  div_run, div_dividend, div_divisor
  );

endinterface

// File: rtl/cplx_div_seq_num_calc.sv
// Combinational numerator/denominator former for (a+jb)/(c+jd):
//   Nre = (ac+bd) << FRAC, Nim = (bc-ad) << FRAC, D = c^2 + d^2.
// With CPLX_ROUND_EN defined, each numerator carries a sign(N)*(D>>1) bias.
module cplx_num_calc
  import cplx_div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [W-1:0]          a_i,
  input  logic signed [W-1:0]          b_i,
  input  logic signed [W-1:0]          c_i,
  input  logic signed [W-1:0]          d_i,
  output logic signed [DIVIDEND_W-1:0] nre_o,
  output logic signed [DIVIDEND_W-1:0] nim_o,
  output logic        [DIVISOR_W-1:0]  d_o
);

  logic signed [DIVIDEND_W-1:0] a_x, b_x, c_x, d_x;
  logic signed [DIVIDEND_W-1:0] re_sum, im_sum;

  // Sign-extend every component to full dividend width before multiplying.
  assign a_x = {{(DIVIDEND_W-W){a_i[W-1]}}, a_i};
  assign b_x = {{(DIVIDEND_W-W){b_i[W-1]}}, b_i};
  assign c_x = {{(DIVIDEND_W-W){c_i[W-1]}}, c_i};
  assign d_x = {{(DIVIDEND_W-W){d_i[W-1]}}, d_i};

  assign re_sum = a_x * c_x + b_x * d_x;
  assign im_sum = b_x * c_x - a_x * d_x;

  // c^2+d^2 peaks at 2*(2^(W-1))^2, which fits the unsigned divisor width.
  assign d_o = DIVISOR_W'(c_x * c_x + d_x * d_x);

`ifdef CPLX_ROUND_EN
  assign nre_o = round_bias(re_sum <<< FRAC, d_o);
  assign nim_o = round_bias(im_sum <<< FRAC, d_o);
`else
  assign nre_o = re_sum <<< FRAC;
  assign nim_o = im_sum <<< FRAC;
`endif

endmodule

// File: rtl/cplx_div_seq.sv
// Complex-divide front-end sequencer. Forms both numerators and the
// denominator, then time-shares one external 32/16 divider: real part
// first, imaginary part second, and presents both quotients together.
// Optional feature macro: CPLX_ROUND_EN (handled inside cplx_num_calc).
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid never waits for ready, and once raised the
// result (out_valid, q_re, q_im, dz) is held unchanged until out_ready.
module cplx_div_seq
  import cplx_div_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic          clock,
  input  logic          reset,
  cplx_div_seq_if.slave bus,
  output state_t        dbg_state_o
);

  state_t state_q, state_d;

  logic signed [W-1:0]          a_q, b_q, c_q, d_q;
  logic signed [DIVIDEND_W-1:0] nim_q;
  logic signed [DIVIDEND_W-1:0] dividend_q;
  logic        [DIVISOR_W-1:0]  divisor_q;
  logic signed [QUOTIENT_W-1:0] q_re_q, q_im_q;
  logic                         dz_q;

  logic signed [DIVIDEND_W-1:0] nre_c, nim_c;
  logic        [DIVISOR_W-1:0]  d_c;

  cplx_num_calc #(
    .W    (W),
    .FRAC (FRAC)
  ) u_num_calc (
    .a_i   (a_q),
    .b_i   (b_q),
    .c_i   (c_q),
    .d_i   (d_q),
    .nre_o (nre_c),
    .nim_o (nim_c),
    .d_o   (d_c)
  );

  // State register; reset aborts any operation back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; div_stop only matters in the two WAIT states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.in_valid) state_d = ST_CALC;
      ST_CALC:    state_d = (d_c == '0) ? ST_DONE : ST_RUN_RE;
      ST_RUN_RE:  if (!bus.div_busy) state_d = ST_WAIT_RE;
      ST_WAIT_RE: if (bus.div_stop) state_d = ST_CAP_RE;
      ST_CAP_RE:  state_d = ST_WAIT_IM;
      ST_WAIT_IM: if (bus.div_stop) state_d = ST_CAP_IM;
      ST_CAP_IM:  state_d = ST_DONE;
      ST_DONE:    if (bus.out_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the second run pulse ignores div_busy because
  // the divider has just finished the real division.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.div_run   = 1'b0;
    case (state_q)
      ST_IDLE:   bus.in_ready  = 1'b1;
      ST_RUN_RE: bus.div_run   = !bus.div_busy;
      ST_CAP_RE: bus.div_run   = 1'b1;
      ST_DONE:   bus.out_valid = 1'b1;
      default:   ;
    endcase
  end

  // Operand capture, numerator registration and quotient capture. The
  // dividend switches to Nim on the edge the real division ends, so it
  // is already in place for the CAP_RE run pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      nim_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      q_re_q     <= '0;
      q_im_q     <= '0;
      dz_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && bus.in_valid) begin
        a_q <= bus.a_re;
        b_q <= bus.a_im;
        c_q <= bus.b_re;
        d_q <= bus.b_im;
      end
      if (state_q == ST_CALC) begin
        if (d_c == '0) begin
          dz_q   <= 1'b1;
          q_re_q <= '0;
          q_im_q <= '0;
        end else begin
          dz_q       <= 1'b0;
          dividend_q <= nre_c;
          nim_q      <= nim_c;
          divisor_q  <= d_c;
        end
      end
      if (state_q == ST_WAIT_RE && bus.div_stop) dividend_q <= nim_q;
      if (state_q == ST_CAP_RE) q_re_q <= bus.div_quotient;
      if (state_q == ST_CAP_IM) q_im_q <= bus.div_quotient;
    end
  end

  assign bus.q_re         = q_re_q;
  assign bus.q_im         = q_im_q;
  assign bus.dz           = dz_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_cplx_div_seq.sv
// Directed plus randomized bench for cplx_div_seq with a behavioural
// 33-cycle divider and a complex-arithmetic reference model.
module tb_cplx_div_seq;
  import cplx_div_pkg::*;

  localparam int W    = W_DEF;
  localparam int FRAC = FRAC_DEF;

  // ---------------- clock / reset ----------------
  logic   clock;
  logic   reset;
  state_t dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cplx_div_seq_if #(.W(W)) bus ();

  cplx_div_seq #(
    .W    (W),
    .FRAC (FRAC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- divider model ----------------
  logic                         model_busy, model_stop;
  logic                         force_busy, inject_stop;
  logic signed [QUOTIENT_W-1:0] model_q;
  logic signed [DIVIDEND_W-1:0] lat_dd;
  logic        [DIVISOR_W-1:0]  lat_dv;
  int                           model_cnt;

  assign bus.div_busy     = model_busy | force_busy;
  assign bus.div_stop     = model_stop | inject_stop;
  assign bus.div_quotient = model_q;

  function automatic logic signed [31:0] div_trunc(input logic signed [31:0] dd,
                                                   input logic [15:0] dv);
    int n, m;
    n = dd;
    m = int'({16'd0, dv});
    if (m == 0) return 32'sh7fff_ffff;
    return n / m;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_busy <= 1'b0;
      model_stop <= 1'b0;
      model_cnt  <= 0;
      model_q    <= '0;
    end else if (model_busy) begin
      if (model_stop) begin
        model_q    <= div_trunc(lat_dd, lat_dv);
        model_busy <= 1'b0;
        model_stop <= 1'b0;
      end else begin
        model_cnt  <= model_cnt + 1;
        model_stop <= (model_cnt + 1 == DIV_LATENCY);
      end
    end else if (bus.div_run) begin
      lat_dd     <= bus.div_dividend;
      lat_dv     <= bus.div_divisor;
      model_busy <= 1'b1;
      model_cnt  <= 1;
      model_stop <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: (a+jb)/(c+jd) = ((ac+bd) + j(bc-ad)) / (c^2+d^2), scaled by 2^FRAC.
  task automatic ref_calc(input int a, b, c, d, output int nre, nim, den);
    den = c * c + d * d;
    nre = (a * c + b * d) * (1 << FRAC);
    nim = (b * c - a * d) * (1 << FRAC);
`ifdef CPLX_ROUND_EN
    if (nre > 0) nre = nre + den / 2; else if (nre < 0) nre = nre - den / 2;
    if (nim > 0) nim = nim + den / 2; else if (nim < 0) nim = nim - den / 2;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_operands(input int a, b, c, d);
    bus.a_re = W'(a);
    bus.a_im = W'(b);
    bus.b_re = W'(c);
    bus.b_im = W'(d);
  endtask

  // One full operation, entered and left at a negedge. busy_until > 0
  // holds div_busy high until that cycle after acceptance.
  task automatic run_op(input int a, b, c, d, input int hold, input int busy_until);
    int nre, nim, den, cyc, runs, valid_cyc, ready_hi, unstable, extra;
    int run_cyc[2];
    string tag;
    logic [64:0] exp_v, snap;
    ref_calc(a, b, c, d, nre, nim, den);
    if (den == 0) exp_v = {1'b1, 64'd0};
    else          exp_v = {1'b0, 32'(nim / den), 32'(nre / den)};
    exp_q.push_back(exp_v);
    extra = (busy_until > 2) ? busy_until - 2 : 0;

    drive_operands(a, b, c, d);
    bus.in_valid = 1'b1;
    force_busy   = (busy_until > 0);
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;

    cyc = 1; runs = 0; valid_cyc = -1; ready_hi = 0;
    run_cyc = '{-1, -1};
    while (valid_cyc < 0 && cyc < 300) begin
      if (cyc == busy_until) begin
        force_busy = 1'b0;
        #1;
      end
      if (bus.in_ready) ready_hi++;
      if (bus.div_run) begin
        if (runs < 2) run_cyc[runs] = cyc;
        tag = (runs == 0) ? "div_dividend_re" : "div_dividend_im";
        check(tag, bus.div_dividend, (runs == 0) ? nre : nim);
        check("div_divisor", bus.div_divisor, den);
        runs++;
      end
      if (bus.out_valid) valid_cyc = cyc;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    force_busy = 1'b0;

    check("run_count", runs, (den == 0) ? 0 : 2);
    check("in_ready_low_busy", ready_hi, 0);
    check("out_valid_latency", valid_cyc, (den == 0) ? 2 : 71 + extra);
    if (den != 0) begin
      check("run_re_cycle", run_cyc[0], 2 + extra);
      check("run_im_cycle", run_cyc[1], 36 + extra);
    end

    exp_v = exp_q.pop_front();
    check("q_re", bus.q_re, $signed(exp_v[31:0]));
    check("q_im", bus.q_im, $signed(exp_v[63:32]));
    check("dz", bus.dz, exp_v[64]);

    // Result must stay put while the consumer stalls; a stray stop is ignored.
    snap = {bus.dz, bus.q_im, bus.q_re};
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      inject_stop = (i == 0);
      @(negedge clock);
      if (!bus.out_valid || bus.in_ready || ({bus.dz, bus.q_im, bus.q_re} != snap))
        unstable++;
    end
    inject_stop = 1'b0;
    check("done_hold_stable", unstable, 0);

    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    check("idle_after_done", bus.in_ready, 1);
    check("out_valid_cleared", bus.out_valid, 0);
  endtask

  // Start an operation and hit reset during cycle at_cyc after acceptance.
  task automatic reset_mid_op(input int a, b, c, d, input int at_cyc);
    int cyc;
    drive_operands(a, b, c, d);
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (cyc < at_cyc) begin
      @(negedge clock);
      cyc++;
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_div_run", bus.div_run, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_q_re", bus.q_re, 0);
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    force_busy    = 1'b0;
    inject_stop   = 1'b0;
    drive_operands(0, 0, 0, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);

    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_q_re", bus.q_re, 0);
    check("reset_q_im", bus.q_im, 0);
    check("reset_dz", bus.dz, 0);
    check("reset_div_run", bus.div_run, 0);
    check("reset_dividend", bus.div_dividend, 0);
    check("reset_divisor", bus.div_divisor, 0);
    reset = 1'b0;

    // Stray stop while idle must not move the FSM.
    inject_stop = 1'b1;
    @(negedge clock);
    inject_stop = 1'b0;
    @(negedge clock);
    check("idle_stray_stop", dbg_state, ST_IDLE);

    run_op(3, 4, 1, 2, 1, 0);           // 563, -102
    run_op(2, 0, 3, 0, 0, 0);           // 170 or 171 with rounding
    run_op(-128, -128, -128, -128, 0, 0); // 256, 0
    run_op(5, 0, 0, 0, 2, 0);           // divide by zero
    run_op(3, 4, 1, 2, 10, 0);          // long consumer stall
    run_op(-7, 9, 4, -3, 0, 5);         // busy divider delays first run
    reset_mid_op(3, 4, 1, 2, 40);
    run_op(1, 1, 1, 1, 0, 0);           // recovery after reset
    run_op(127, -128, 127, -128, 0, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
